// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array feed logic.
//   skew_state_t : control state of the input skewer (stream / drain / done)
//   lane_lsb()   : bit offset of lane i inside a packed row vector, where
//                  lane 0 occupies the most significant slice.
package systolic_pkg;

    typedef enum logic [1:0] {
        S_STREAM = 2'd0,
        S_DRAIN  = 2'd1,
        S_DONE   = 2'd2
    } skew_state_t;

    // Lane 0 sits in the top slice so the row reads left-to-right as lane order.
    function automatic int lane_lsb(input int width, input int lanes, input int lane);
        return width * (lanes - 1 - lane);
    endfunction

endpackage

// File: rtl/skew_delay_line.sv
// Fixed-depth register chain carrying one lane element plus its valid flag.
//   clk, rstn  : clock, asynchronous active-low reset (clears every stage)
//   in_valid   : valid flag entering stage 0
//   din        : lane element entering stage 0 (caller zero-fills bubbles)
//   out_valid  : valid flag leaving the last stage
//   dout       : lane element leaving the last stage
//   any_valid  : some stage of the chain currently holds valid data
module skew_delay_line #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] din,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  any_valid
);

    logic [DEPTH-1:0]      vld;
    logic [DATA_WIDTH-1:0] data [DEPTH];

    // Every stage shifts each cycle; there is no stall path.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                data[k] <= '0;
            end
        end else begin
            vld[0]  <= in_valid;
            data[0] <= din;
            for (int k = 1; k < DEPTH; k++) begin
                vld[k]  <= vld[k-1];
                data[k] <= data[k-1];
            end
        end
    end

    assign out_valid = vld[DEPTH-1];
    assign dout      = data[DEPTH-1];
    assign any_valid = |vld;

endmodule

// File: rtl/systolic_input_skewer.sv
// Feed-side skew buffer for the systolic array. Each accepted row vector is
// split into lanes and lane i is delayed by i+1 cycles, so operands enter the
// array as a diagonal wavefront. After the vector flagged in_last, input is
// closed while the wavefront drains, and done pulses when that vector's last
// lane reaches the array.
//   clk, rstn  : clock, asynchronous active-low reset
//   in_valid   : din holds a vector this cycle
//   in_last    : final vector of a tile (only meaningful with in_valid)
//   din        : packed row, lane i at din[DATA_WIDTH*(length-1-i) +: DATA_WIDTH]
//   in_ready   : a vector is accepted this cycle when in_valid is also high
//   dout       : skewed lanes, same packing as din
//   out_valid  : per-lane qualifier for dout
//   busy       : data in flight, or the tile is draining / finishing
//   done       : one-cycle pulse when the last vector has left lane length-1
module systolic_input_skewer
    import systolic_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int length     = 16
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         in_valid,
    input  logic                         in_last,
    input  logic [DATA_WIDTH*length-1:0] din,
    output logic                         in_ready,
    output logic [DATA_WIDTH*length-1:0] dout,
    output logic [length-1:0]            out_valid,
    output logic                         busy,
    output logic                         done
);

    localparam int CNT_W = (length > 1) ? $clog2(length) : 1;

    skew_state_t      state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             accept;
    logic [length-1:0] lane_busy;

    assign accept = in_valid && in_ready;

    // One delay line per lane, lane i being i+1 stages deep. Cycles without an
    // accepted vector push a zero element with valid low, which is how bubbles
    // and the drain tail show up as zeros on dout.
    for (genvar i = 0; i < length; i++) begin : g_lane
        localparam int LSB = lane_lsb(DATA_WIDTH, length, i);

        skew_delay_line #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (i + 1)
        ) u_line (
            .clk       (clk),
            .rstn      (rstn),
            .in_valid  (accept),
            .din       (accept ? din[LSB +: DATA_WIDTH] : {DATA_WIDTH{1'b0}}),
            .out_valid (out_valid[i]),
            .dout      (dout[LSB +: DATA_WIDTH]),
            .any_valid (lane_busy[i])
        );
    end

    // State and drain counter registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= S_STREAM;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // The drain count is loaded with length-1 so that S_DONE lands in the same
    // cycle the last vector's final lane comes out; it stops at 1.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            S_STREAM: begin
                if (accept && in_last) begin
                    if (length == 1) begin
                        state_next = S_DONE;
                    end else begin
                        state_next = S_DRAIN;
                        cnt_next   = CNT_W'(length - 1);
                    end
                end
            end
            S_DRAIN: begin
                if (cnt == CNT_W'(1)) begin
                    state_next = S_DONE;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            S_DONE: begin
                state_next = S_STREAM;
            end
            default: begin
                state_next = S_STREAM;
            end
        endcase
    end

    assign in_ready = (state == S_STREAM);
    assign done     = (state == S_DONE);
    assign busy     = (|lane_busy) || (state != S_STREAM);

endmodule

// File: tb/tb_systolic_input_skewer.sv
// Directed bench for systolic_input_skewer: a length=4 instance exercises
// streaming, bubbles, drain, input blocking and reset mid-drain; a length=1
// instance checks the single-lane done timing. Inputs change 1 time unit
// after a rising edge and outputs are checked there as well.
module tb_systolic_input_skewer;

    logic        clk;
    logic        rstn;

    logic        in_valid;
    logic        in_last;
    logic [31:0] din;
    logic        in_ready;
    logic [31:0] dout;
    logic [3:0]  out_valid;
    logic        busy;
    logic        done;

    logic        in_valid1;
    logic        in_last1;
    logic [7:0]  din1;
    logic        in_ready1;
    logic [7:0]  dout1;
    logic [0:0]  out_valid1;
    logic        busy1;
    logic        done1;

    int total;
    int bad;

    systolic_input_skewer #(.DATA_WIDTH(8), .length(4)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .din       (din),
        .in_ready  (in_ready),
        .dout      (dout),
        .out_valid (out_valid),
        .busy      (busy),
        .done      (done)
    );

    systolic_input_skewer #(.DATA_WIDTH(8), .length(1)) dut1 (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid1),
        .in_last   (in_last1),
        .din       (din1),
        .in_ready  (in_ready1),
        .dout      (dout1),
        .out_valid (out_valid1),
        .busy      (busy1),
        .done      (done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of input on the length=4 instance, then move into the next cycle.
    task automatic applyStimulus(input logic v, input logic l, input logic [31:0] d);
        in_valid = v;
        in_last  = l;
        din      = d;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] exp_dout,
                               input logic [3:0] exp_valid, input logic exp_ready,
                               input logic exp_done, input logic exp_busy);
        checkVal({tag, ".dout"},      dout,               exp_dout);
        checkVal({tag, ".out_valid"}, {28'd0, out_valid}, {28'd0, exp_valid});
        checkVal({tag, ".in_ready"},  {31'd0, in_ready},  {31'd0, exp_ready});
        checkVal({tag, ".done"},      {31'd0, done},      {31'd0, exp_done});
        checkVal({tag, ".busy"},      {31'd0, busy},      {31'd0, exp_busy});
    endtask

    task automatic step(input string tag, input logic v, input logic l, input logic [31:0] d,
                        input logic [31:0] exp_dout, input logic [3:0] exp_valid,
                        input logic exp_ready, input logic exp_done, input logic exp_busy);
        applyStimulus(v, l, d);
        checkOutput(tag, exp_dout, exp_valid, exp_ready, exp_done, exp_busy);
    endtask

    task automatic checkSingle(input string tag, input logic [7:0] exp_dout, input logic exp_valid,
                               input logic exp_ready, input logic exp_done, input logic exp_busy);
        checkVal({tag, ".dout"},      {24'd0, dout1},      {24'd0, exp_dout});
        checkVal({tag, ".out_valid"}, {31'd0, out_valid1}, {31'd0, exp_valid});
        checkVal({tag, ".in_ready"},  {31'd0, in_ready1},  {31'd0, exp_ready});
        checkVal({tag, ".done"},      {31'd0, done1},      {31'd0, exp_done});
        checkVal({tag, ".busy"},      {31'd0, busy1},      {31'd0, exp_busy});
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rstn      = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        din       = '0;
        in_valid1 = 1'b0;
        in_last1  = 1'b0;
        din1      = '0;

        // Test 1: reset state on the first cycle after release.
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        checkOutput("t1_reset", 32'h0, 4'b0000, 1'b1, 1'b0, 1'b0);
        checkSingle("t1_reset_len1", 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);

        // Test 2: single vector with in_last.
        step("t2_c1", 1'b1, 1'b1, 32'h11223344, 32'h11000000, 4'b0001, 1'b0, 1'b0, 1'b1);
        step("t2_c2", 1'b0, 1'b0, 32'h0,        32'h00220000, 4'b0010, 1'b0, 1'b0, 1'b1);
        step("t2_c3", 1'b0, 1'b0, 32'h0,        32'h00003300, 4'b0100, 1'b0, 1'b0, 1'b1);
        step("t2_c4", 1'b0, 1'b0, 32'h0,        32'h00000044, 4'b1000, 1'b0, 1'b1, 1'b1);
        step("t2_c5", 1'b0, 1'b0, 32'h0,        32'h00000000, 4'b0000, 1'b1, 1'b0, 1'b0);

        // Test 3: three back-to-back vectors A, B, C(last).
        step("t3_c1", 1'b1, 1'b0, 32'h01020304, 32'h01000000, 4'b0001, 1'b1, 1'b0, 1'b1);
        step("t3_c2", 1'b1, 1'b0, 32'h05060708, 32'h05020000, 4'b0011, 1'b1, 1'b0, 1'b1);
        step("t3_c3", 1'b1, 1'b1, 32'h090A0B0C, 32'h09060300, 4'b0111, 1'b0, 1'b0, 1'b1);
        step("t3_c4", 1'b0, 1'b0, 32'h0,        32'h000A0704, 4'b1110, 1'b0, 1'b0, 1'b1);
        step("t3_c5", 1'b0, 1'b0, 32'h0,        32'h00000B08, 4'b1100, 1'b0, 1'b0, 1'b1);
        step("t3_c6", 1'b0, 1'b0, 32'h0,        32'h0000000C, 4'b1000, 1'b0, 1'b1, 1'b1);
        step("t3_c7", 1'b0, 1'b0, 32'h0,        32'h00000000, 4'b0000, 1'b1, 1'b0, 1'b0);

        // Test 4: A, bubble, B(last); in_last without in_valid in the bubble is ignored.
        step("t4_c1", 1'b1, 1'b0, 32'hA1A2A3A4, 32'hA1000000, 4'b0001, 1'b1, 1'b0, 1'b1);
        step("t4_c2", 1'b0, 1'b1, 32'hEEEEEEEE, 32'h00A20000, 4'b0010, 1'b1, 1'b0, 1'b1);
        step("t4_c3", 1'b1, 1'b1, 32'hB1B2B3B4, 32'hB100A300, 4'b0101, 1'b0, 1'b0, 1'b1);
        step("t4_c4", 1'b0, 1'b0, 32'h0,        32'h00B200A4, 4'b1010, 1'b0, 1'b0, 1'b1);
        step("t4_c5", 1'b0, 1'b0, 32'h0,        32'h0000B300, 4'b0100, 1'b0, 1'b0, 1'b1);
        step("t4_c6", 1'b0, 1'b0, 32'h0,        32'h000000B4, 4'b1000, 1'b0, 1'b1, 1'b1);
        step("t4_c7", 1'b0, 1'b0, 32'h0,        32'h00000000, 4'b0000, 1'b1, 1'b0, 1'b0);

        // Test 5: vectors offered during drain never enter.
        step("t5_c1", 1'b1, 1'b1, 32'h10203040, 32'h10000000, 4'b0001, 1'b0, 1'b0, 1'b1);
        step("t5_c2", 1'b1, 1'b0, 32'hFFFFFFFF, 32'h00200000, 4'b0010, 1'b0, 1'b0, 1'b1);
        step("t5_c3", 1'b1, 1'b0, 32'hFFFFFFFF, 32'h00003000, 4'b0100, 1'b0, 1'b0, 1'b1);
        step("t5_c4", 1'b1, 1'b1, 32'hFFFFFFFF, 32'h00000040, 4'b1000, 1'b0, 1'b1, 1'b1);
        step("t5_c5", 1'b1, 1'b0, 32'hFFFFFFFF, 32'h00000000, 4'b0000, 1'b1, 1'b0, 1'b0);
        step("t5_c6", 1'b0, 1'b0, 32'h0,        32'h00000000, 4'b0000, 1'b1, 1'b0, 1'b0);

        // Test 6: reset two cycles into drain clears everything at once.
        step("t6_c1", 1'b1, 1'b1, 32'h55667788, 32'h55000000, 4'b0001, 1'b0, 1'b0, 1'b1);
        step("t6_c2", 1'b0, 1'b0, 32'h0,        32'h00660000, 4'b0010, 1'b0, 1'b0, 1'b1);
        #1;
        rstn = 1'b0;
        #1;
        checkOutput("t6_async", 32'h0, 4'b0000, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("t6_hold", 32'h0, 4'b0000, 1'b1, 1'b0, 1'b0);
        rstn = 1'b1;
        step("t6_r1", 1'b0, 1'b0, 32'h0, 32'h0, 4'b0000, 1'b1, 1'b0, 1'b0);
        step("t6_r2", 1'b0, 1'b0, 32'h0, 32'h0, 4'b0000, 1'b1, 1'b0, 1'b0);
        step("t6_r3", 1'b0, 1'b0, 32'h0, 32'h0, 4'b0000, 1'b1, 1'b0, 1'b0);

        // Test 7: length=1 instance, done in the cycle right after acceptance.
        in_valid1 = 1'b1;
        in_last1  = 1'b1;
        din1      = 8'h5A;
        @(posedge clk);
        #1;
        in_valid1 = 1'b0;
        in_last1  = 1'b0;
        din1      = 8'h00;
        checkSingle("t7_c1", 8'h5A, 1'b1, 1'b0, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        checkSingle("t7_c2", 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
